// File: rtl/ir_carrier_detector.sv
// IR carrier detector: measures rising-edge period of the receiver output, classifies it
// into one of three carrier bins, locks after a run of matching periods, reports burst length.
module ir_carrier_detector #(
   parameter int PERIOD_A   = 400,
   parameter int PERIOD_B   = 600,
   parameter int PERIOD_C   = 800,
   parameter int TOL        = 40,
   parameter int LOCK_COUNT = 4,
   parameter int TIMEOUT    = 2000,
   parameter int CNT_W      = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_rx_in,
   output logic             o_carrier_valid,
   output logic [1:0]       o_carrier_code,
   output logic             o_period_strobe,
   output logic [CNT_W-1:0] o_period_out,
   output logic             o_burst_done,
   output logic [15:0]      o_burst_count
);

   localparam int MC_W = $clog2(LOCK_COUNT + 1);

   typedef enum logic [1:0] {S_IDLE, S_ACQ, S_LOCK} state_t;

   state_t            r_state, w_state_nxt;
   logic              r_sync1, r_sync2, r_sync2_d;
   logic [CNT_W-1:0]  r_per_cnt;
   logic [1:0]        r_cand, w_cand_nxt;
   logic [MC_W-1:0]   r_match, w_match_nxt;
   logic [1:0]        r_code, w_code_nxt;
   logic [15:0]       r_bcnt, w_bcnt_nxt;
   logic              r_done, w_done_nxt;
   logic              r_strobe;
   logic [CNT_W-1:0]  r_period;
   logic              w_rise, w_tmo;
   logic [1:0]        w_cls;

   // Unsigned distance so small periods never wrap into a bin.
   function automatic logic in_bin(input logic [CNT_W-1:0] p, input int nom);
      logic [CNT_W-1:0] n, d;
      n = CNT_W'(nom);
      d = (p >= n) ? (p - n) : (n - p);
      return (d <= CNT_W'(TOL));
   endfunction

   function automatic logic [1:0] classify(input logic [CNT_W-1:0] p);
      if (in_bin(p, PERIOD_A))      return 2'd1;
      else if (in_bin(p, PERIOD_B)) return 2'd2;
      else if (in_bin(p, PERIOD_C)) return 2'd3;
      else                          return 2'd0;
   endfunction

   assign w_rise = r_sync2 & ~r_sync2_d;
   assign w_tmo  = (r_per_cnt == CNT_W'(TIMEOUT));
   assign w_cls  = classify(r_per_cnt);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sync1   <= 1'b0;
         r_sync2   <= 1'b0;
         r_sync2_d <= 1'b0;
         r_per_cnt <= '0;
         r_state   <= S_IDLE;
         r_cand    <= '0;
         r_match   <= '0;
         r_code    <= '0;
         r_bcnt    <= '0;
         r_done    <= 1'b0;
         r_strobe  <= 1'b0;
         r_period  <= '0;
      end else begin
         r_sync1   <= i_rx_in;
         r_sync2   <= r_sync1;
         r_sync2_d <= r_sync2;
         if (w_rise)      r_per_cnt <= CNT_W'(1);
         else if (!w_tmo) r_per_cnt <= r_per_cnt + 1'b1;
         r_state   <= w_state_nxt;
         r_cand    <= w_cand_nxt;
         r_match   <= w_match_nxt;
         r_code    <= w_code_nxt;
         r_bcnt    <= w_bcnt_nxt;
         r_done    <= w_done_nxt;
         r_strobe  <= w_rise && (r_state != S_IDLE);
         if (w_rise && (r_state != S_IDLE)) r_period <= r_per_cnt;
      end
   end

   // A rise always takes priority over a coincident timeout.
   always_comb begin
      w_state_nxt = r_state;
      w_cand_nxt  = r_cand;
      w_match_nxt = r_match;
      w_code_nxt  = r_code;
      w_bcnt_nxt  = r_bcnt;
      w_done_nxt  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_rise) begin
               w_state_nxt = S_ACQ;
               w_cand_nxt  = '0;
               w_match_nxt = '0;
            end
         end
         S_ACQ: begin
            if (w_rise) begin
               if ((w_cls != 2'd0) && (w_cls == r_cand)) begin
                  w_match_nxt = r_match + 1'b1;
                  if ((r_match + 1'b1) == MC_W'(LOCK_COUNT)) begin
                     w_state_nxt = S_LOCK;
                     w_code_nxt  = w_cls;
                     w_bcnt_nxt  = 16'(LOCK_COUNT);
                  end
               end else if (w_cls != r_cand) begin
                  w_cand_nxt  = w_cls;
                  w_match_nxt = (w_cls != 2'd0) ? MC_W'(1) : '0;
                  if ((w_cls != 2'd0) && (LOCK_COUNT == 1)) begin
                     w_state_nxt = S_LOCK;
                     w_code_nxt  = w_cls;
                     w_bcnt_nxt  = 16'd1;
                  end
               end
            end else if (w_tmo) begin
               w_state_nxt = S_IDLE;
            end
         end
         S_LOCK: begin
            if (w_rise) begin
               if (w_cls == r_code) begin
                  if (r_bcnt != 16'hFFFF) w_bcnt_nxt = r_bcnt + 1'b1;
               end else begin
                  w_state_nxt = S_ACQ;
                  w_cand_nxt  = w_cls;
                  w_match_nxt = (w_cls != 2'd0) ? MC_W'(1) : '0;
                  w_code_nxt  = '0;
                  w_done_nxt  = 1'b1;
               end
            end else if (w_tmo) begin
               w_state_nxt = S_IDLE;
               w_code_nxt  = '0;
               w_done_nxt  = 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      o_carrier_valid = (r_state == S_LOCK);
      o_carrier_code  = (r_state == S_LOCK) ? r_code : 2'd0;
      o_period_strobe = r_strobe;
      o_period_out    = r_period;
      o_burst_done    = r_done;
      o_burst_count   = r_bcnt;
   end

endmodule

// File: tb/tb_ir_carrier_detector.sv
// Scoreboard bench for ir_carrier_detector: a period-level model pushes expected
// strobe/lock/done events with their cycle stamps; a negedge monitor pops and compares.
module tb_ir_carrier_detector;
   localparam int TIMEOUT = 2000;

   logic        clk = 1'b0;
   logic        rst, rx;
   logic        valid, strobe, done;
   logic [1:0]  code;
   logic [15:0] period, bcount;

   ir_carrier_detector dut (
      .i_clk(clk), .i_rst(rst), .i_rx_in(rx),
      .o_carrier_valid(valid), .o_carrier_code(code),
      .o_period_strobe(strobe), .o_period_out(period),
      .o_burst_done(done), .o_burst_count(bcount)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // kind: 0 strobe (period), 1 burst_done (burst_count), 2 lock (code)
   typedef struct {int kind; int val; int cyc;} ev_t;
   ev_t q[$];

   int checks = 0, errors = 0;
   int m_st = 0, m_cand = 0, m_mcnt = 0, m_code = 0, m_bcnt = 0, m_last = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic expect_ev(input int k, input logic [31:0] v);
      ev_t e;
      if (q.size() == 0) chk("unexpected_event_kind", k, -1);
      else begin
         e = q.pop_front();
         chk("ev_kind", k, e.kind);
         chk("ev_value", v, e.val);
         chk("ev_cycle", cyc, e.cyc);
      end
   endtask

   logic pv = 1'b0;
   always @(negedge clk) begin
      if (rst) pv <= 1'b0;
      else begin
         if (strobe) expect_ev(0, period);
         if (done) expect_ev(1, bcount);
         if (valid && !pv) expect_ev(2, code);
         pv <= valid;
      end
   end

   function automatic int cls(input int p);
      if (p >= 400 - 40 && p <= 400 + 40) return 1;
      if (p >= 600 - 40 && p <= 600 + 40) return 2;
      if (p >= 800 - 40 && p <= 800 + 40) return 3;
      return 0;
   endfunction

   task automatic push(input int k, input int v, input int c);
      q.push_back('{k, v, c});
   endtask

   // Rise driven at cycle n is acted on at posedge n+3 (2-flop sync + edge detect + register).
   task automatic model_rise(input int p);
      int c;
      if (m_st == 0) begin
         m_st = 1; m_cand = 0; m_mcnt = 0;
      end else begin
         push(0, p, cyc + 3);
         c = cls(p);
         if (m_st == 1) begin
            if (c != 0 && c == m_cand) begin
               m_mcnt++;
               if (m_mcnt == 4) begin
                  m_st = 2; m_code = c; m_bcnt = 4;
                  push(2, c, cyc + 3);
               end
            end else if (c != m_cand) begin
               m_cand = c; m_mcnt = (c != 0) ? 1 : 0;
            end
         end else begin
            if (c == m_code) begin
               if (m_bcnt < 65535) m_bcnt++;
            end else begin
               push(1, m_bcnt, cyc + 3);
               m_st = 1; m_cand = c; m_mcnt = (c != 0) ? 1 : 0;
            end
         end
      end
      m_last = cyc;
   endtask

   task automatic first_rise();
      @(posedge clk); #1;
      rx = 1'b1;
      model_rise(0);
   endtask

   task automatic rise(input int gap);
      for (int i = 1; i <= gap; i++) begin
         @(posedge clk); #1;
         rx = (i == gap) || (i < gap / 2);
      end
      model_rise(gap);
   endtask

   // Silence long enough to time out; only ever lowers rx.
   task automatic quiet(input int n);
      if (m_st == 2) push(1, m_bcnt, m_last + TIMEOUT + 3);
      m_st = 0;
      for (int i = 1; i <= n; i++) begin
         @(posedge clk); #1;
         rx = rx & (i < 400);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_valid"}, valid, 0);
      chk({tag, "_code"}, code, 0);
      chk({tag, "_strobe"}, strobe, 0);
      chk({tag, "_period"}, period, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_bcount"}, bcount, 0);
   endtask

   initial begin
      rx  = 1'b0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk_zero("rst");

      // 800-cycle carrier, 10 measured periods, then timeout
      first_rise();
      repeat (10) rise(800);
      quiet(2100);

      // jitter inside tolerance locks; 759 is just outside and drops lock
      first_rise();
      rise(760); rise(840); rise(800); rise(760);
      rise(759);
      quiet(2100);

      // out-of-bin period: strobes only, never locks
      first_rise();
      repeat (6) rise(700);
      quiet(2100);

      // carrier switch C -> A with no gap
      first_rise();
      repeat (6) rise(800);
      repeat (6) rise(400);
      quiet(2100);

      // reset while locked: outputs clear, no burst_done, fresh acquisition
      first_rise();
      repeat (5) rise(800);
      for (int i = 1; i <= 500; i++) begin
         @(posedge clk); #1;
         rx = rx & (i < 400);
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      m_st = 0;
      @(negedge clk);
      chk_zero("midrst");
      first_rise();
      repeat (4) rise(800);
      quiet(2100);

      // lone rise: IDLE -> ACQUIRE -> IDLE, no events
      first_rise();
      quiet(2100);

      // tolerance edges 440/360, then a rise coinciding with timeout (period 2000)
      first_rise();
      rise(440); rise(360); rise(400); rise(440);
      rise(2000);
      quiet(2100);

      repeat (5) @(posedge clk);
      chk("queue_empty", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
